if_id_queue: RTL and testbench

- Parametrised instruction buffer between the instruction-cache/fetch stage and the decode stage.
- Successor to the single-entry hold register in the decode stage. Holds up to DEPTH fetched {excepttype, pc, inst} entries so fetch can keep running while decode is stalled.
- Supports flush (exception), branch kill that preserves the delay slot, and an occupancy count.
- Presents a zeroed bubble to decode when empty.

---
 rtl/if_id_queue_if.sv | 29 ++
 rtl/if_id_queue.sv | 98 +++++++++
 tb/tb_if_id_queue.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// The slave modport is the queue; the master side drives fetch data and decode ready.
interface if_id_queue_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int EXC_W  = 32
);
    logic              ic_valid;
    logic [PC_W-1:0]   ic_pc;
    logic [INST_W-1:0] ic_inst;
    logic [EXC_W-1:0]  ic_excepttype;
    logic              ic_ready;

    logic              id_ready;
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [INST_W-1:0] id_inst;
    logic [EXC_W-1:0]  id_excepttype;

    modport master (
        output ic_valid, ic_pc, ic_inst, ic_excepttype, id_ready,
        input  ic_ready, id_valid, id_pc, id_inst, id_excepttype
    );

    modport slave (
        input  ic_valid, ic_pc, ic_inst, ic_excepttype, id_ready,
        output ic_ready, id_valid, id_pc, id_inst, id_excepttype
    );
endinterface

// File: rtl/if_id_queue.sv
// Circular instruction buffer between fetch and decode with exception flush,
// branch kill that keeps the delay slot, and a zeroed bubble when empty.
module if_id_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int EXC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     br_e,
    if_id_queue_if.slave             q_bus,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = EXC_W + PC_W + INST_W;

    logic [ENT_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             empty;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic [ENT_W-1:0] head;

    assign empty = (count_q == '0);

    // Ready depends only on registered occupancy, so a full queue refuses a push
    // even when decode pops in the same cycle.
    assign q_bus.ic_ready = (count_q != CNT_W'(DEPTH));

    assign push = q_bus.ic_valid & q_bus.ic_ready;
    assign pop  = q_bus.id_valid & q_bus.id_ready;

    assign wr_en = push & ~flush & ~br_e;

    assign head = mem_q[rd_ptr_q];

    assign q_bus.id_valid      = ~empty;
    assign q_bus.id_excepttype = empty ? '0 : head[ENT_W-1 -: EXC_W];
    assign q_bus.id_pc         = empty ? '0 : head[PC_W+INST_W-1 -: PC_W];
    assign q_bus.id_inst       = empty ? '0 : head[INST_W-1:0];

    assign count = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (br_e) begin
            if (!empty && !q_bus.id_ready) begin
                // Decode is stalled: keep only the head, which is the delay slot.
                wr_ptr_d = rd_ptr_q + PTR_W'(1);
                count_d  = CNT_W'(1);
            end else begin
                rd_ptr_d = wr_ptr_q;
                count_d  = '0;
            end
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty queue masks the head to zero.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= {q_bus.ic_excepttype, q_bus.ic_pc, q_bus.ic_inst};
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic,
// compared each cycle against a queue-based behavioural model.
module tb_if_id_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] exc;
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       br_e;
    logic [2:0] count;

    always #5 clk = ~clk;

    if_id_queue_if #(.PC_W(32), .INST_W(32), .EXC_W(32)) bus ();

    if_id_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32), .EXC_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .br_e  (br_e),
        .q_bus (bus),
        .count (count)
    );

    ent_t        mq[$];
    logic [31:0] popped[$];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("count",         64'(count),              64'(mq.size()));
        chk("id_valid",      64'(bus.id_valid),       64'(mq.size() != 0));
        chk("ic_ready",      64'(bus.ic_ready),       64'(mq.size() != DEPTH));
        chk("id_pc",         64'(bus.id_pc),          64'(h.pc));
        chk("id_inst",       64'(bus.id_inst),        64'(h.inst));
        chk("id_excepttype", 64'(bus.id_excepttype),  64'(h.exc));
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input bit v, input logic [31:0] pc, input bit rdy,
                        input bit fl = 1'b0, input bit br = 1'b0, input bit rs = 1'b0);
        ent_t e;
        bit   do_push;
        bit   do_pop;
        e.pc   = pc;
        e.inst = $urandom;
        e.exc  = $urandom;
        rst = rs; flush = fl; br_e = br;
        bus.ic_valid = v; bus.ic_pc = pc; bus.ic_inst = e.inst; bus.ic_excepttype = e.exc;
        bus.id_ready = rdy;
        if (!rs && !fl && bus.id_valid && rdy) popped.push_back(bus.id_pc);

        do_push = v && (mq.size() != DEPTH);
        do_pop  = (mq.size() != 0) && rdy;
        if (rs || fl) begin
            mq.delete();
        end else if (br) begin
            if (mq.size() != 0 && !rdy) begin
                while (mq.size() > 1) void'(mq.pop_back());
            end else begin
                if (do_pop) $display("[TB] t=%0t pop  pc=%h (delay slot)", $time, mq[0].pc);
                mq.delete();
            end
        end else begin
            if (do_pop) begin
                $display("[TB] t=%0t pop  pc=%h", $time, mq[0].pc);
                void'(mq.pop_front());
            end
            if (do_push) begin
                $display("[TB] t=%0t push pc=%h", $time, pc);
                mq.push_back(e);
            end
        end

        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int cyc;
        bit acc;
        rst = 1'b1; flush = 1'b0; br_e = 1'b0;
        bus.ic_valid = 1'b0; bus.ic_pc = '0; bus.ic_inst = '0; bus.ic_excepttype = '0;
        bus.id_ready = 1'b0;
        @(negedge clk);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_count",    64'(count),        64'd0);
        chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
        chk("rst_ic_ready", 64'(bus.ic_ready), 64'd1);
        chk("rst_id_pc",    64'(bus.id_pc),    64'd0);

        // Two pushes with decode stalled
        step(1'b1, 32'hBFC0_0000, 1'b0);
        step(1'b1, 32'hBFC0_0004, 1'b0);
        chk("t1_count",    64'(count),        64'd2);
        chk("t1_head_pc",  64'(bus.id_pc),    64'hBFC0_0000);
        chk("t1_ic_ready", 64'(bus.ic_ready), 64'd1);
        step(1'b0, $urandom, 1'b0, 1'b1);

        // Full queue refuses a push even with a simultaneous pop
        for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + 32'(4 * i), 1'b0);
        chk("t2_full_count", 64'(count),        64'd4);
        chk("t2_ic_ready",   64'(bus.ic_ready), 64'd0);
        step(1'b1, 32'h20, 1'b1);
        chk("t2_count", 64'(count),     64'd3);
        chk("t2_head",  64'(bus.id_pc), 64'h14);
        for (int i = 0; i < 3; i++) step(1'b0, $urandom, 1'b1);
        chk("t2_drained", 64'(count), 64'd0);

        // Branch with decode ready: head delivered, rest killed
        step(1'b1, 32'h100, 1'b0);
        step(1'b1, 32'h104, 1'b0);
        step(1'b1, 32'h108, 1'b0);
        popped.delete();
        step(1'b1, 32'h10C, 1'b1, 1'b0, 1'b1);
        chk("t3_pop_n",    64'(popped.size()), 64'd1);
        chk("t3_pop_pc",   64'(popped[0]),     64'h100);
        chk("t3_count",    64'(count),         64'd0);
        chk("t3_id_valid", 64'(bus.id_valid),  64'd0);
        chk("t3_id_inst",  64'(bus.id_inst),   64'd0);

        // Branch with decode stalled: delay slot kept
        step(1'b1, 32'h100, 1'b0);
        step(1'b1, 32'h104, 1'b0);
        step(1'b1, 32'h108, 1'b0);
        step(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        chk("t4_count", 64'(count),     64'd1);
        chk("t4_head",  64'(bus.id_pc), 64'h100);
        step(1'b0, $urandom, 1'b1);
        chk("t4_after", 64'(count), 64'd0);

        // Flush while full drops everything including the incoming push
        for (int i = 0; i < 4; i++) step(1'b1, 32'h40 + 32'(4 * i), 1'b0);
        step(1'b1, 32'h400, 1'b0, 1'b1);
        chk("t5_count",    64'(count),        64'd0);
        chk("t5_ic_ready", 64'(bus.ic_ready), 64'd1);
        step(1'b1, 32'h200, 1'b0);
        chk("t5_head",  64'(bus.id_pc),    64'h200);
        chk("t5_valid", 64'(bus.id_valid), 64'd1);
        step(1'b0, $urandom, 1'b0, 1'b1);

        // Stream across pointer wrap with decode toggling
        popped.delete();
        n = 0;
        cyc = 0;
        while ((n < 10 || mq.size() != 0) && cyc < 100) begin
            acc = (n < 10) && (mq.size() != DEPTH);
            step(n < 10, 32'h1000 + 32'(4 * n), (cyc % 2) == 0);
            if (acc) n++;
            cyc++;
        end
        chk("t6_pop_n", 64'(popped.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < popped.size()) chk("t6_order", 64'(popped[i]), 64'h1000 + 64'(4 * i));
        end

        // Random traffic with garbage on idle fetch cycles
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 7,
                 $urandom_range(0, 99) < 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
